// File: rtl/unified_mem_ctrl_if.sv
// Request/response bundle between the IF/MEM pipeline stages and unified_mem_ctrl.
// MISALIGN_TRAP_EN adds the misalign_err response signal.
interface unified_mem_ctrl_if;
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_rdata;
  logic        if_valid;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_done;
  logic        freeze_pc;
  logic        stall_mem;
  logic        busy;
`ifdef MISALIGN_TRAP_EN
  logic        misalign_err;
`endif

  // Controller side: takes requests, returns data and hazard flags.
  modport slave (
    input  if_req, if_addr, mem_read, mem_write, mem_addr, mem_wdata,
    output if_rdata, if_valid, mem_rdata, mem_done, freeze_pc, stall_mem, busy
`ifdef MISALIGN_TRAP_EN
    , output misalign_err
`endif
  );

  // Pipeline side: issues fetch and load/store requests.
  modport master (
    output if_req, if_addr, mem_read, mem_write, mem_addr, mem_wdata,
    input  if_rdata, if_valid, mem_rdata, mem_done, freeze_pc, stall_mem, busy
`ifdef MISALIGN_TRAP_EN
    , input misalign_err
`endif
  );
endinterface

// File: rtl/unified_mem_ctrl.sv
// Shared instruction/data memory port: data-priority arbitration, programmable wait states,
// PC freeze and MEM stall generation. Optional MISALIGN_TRAP_EN traps odd byte addresses.
module unified_mem_ctrl #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rest,
  unified_mem_ctrl_if.slave bus
);

  localparam int         DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
`ifdef MISALIGN_TRAP_EN
  localparam logic       TRAP_EN   = 1'b1;
`else
  localparam logic       TRAP_EN   = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    DATA_ACC,
    FETCH_ACC
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              wait_cnt_q, wait_cnt_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic                    wr_q, wr_d;
  logic [15:0]             wdata_q, wdata_d;
  logic                    mis_q, mis_d;
  logic [15:0]             if_rdata_q;
  logic [15:0]             mem_rdata_q;
  logic [15:0]             mem_q [DEPTH];

  logic                    data_req;
  logic                    final_cyc;
  logic                    data_fin;
  logic                    fetch_fin;
  logic                    store_en;
  logic [15:0]             rd_word;
  logic                    unused_addr_bits;

  assign data_req = bus.mem_read | bus.mem_write;

  // Only addr[DEPTH_LOG2:1] selects a word; the rest wrap or are ignored.
  assign unused_addr_bits = ^{bus.if_addr, bus.mem_addr};

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    idx_d      = idx_q;
    wr_d       = wr_q;
    wdata_d    = wdata_q;
    mis_d      = mis_q;
    unique case (state_q)
      IDLE: begin
        if (data_req) begin
          state_d    = DATA_ACC;
          wait_cnt_d = WAIT_INIT;
          idx_d      = bus.mem_addr[DEPTH_LOG2:1];
          wr_d       = bus.mem_write;
          wdata_d    = bus.mem_wdata;
          mis_d      = TRAP_EN & bus.mem_addr[0];
        end else if (bus.if_req) begin
          state_d    = FETCH_ACC;
          wait_cnt_d = WAIT_INIT;
          idx_d      = bus.if_addr[DEPTH_LOG2:1];
          wr_d       = 1'b0;
          wdata_d    = bus.mem_wdata;
          mis_d      = TRAP_EN & bus.if_addr[0];
        end
      end
      DATA_ACC, FETCH_ACC: begin
        if (wait_cnt_q != 4'd0) begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign final_cyc = (state_q != IDLE) && (wait_cnt_q == 4'd0);
  assign data_fin  = final_cyc && (state_q == DATA_ACC);
  assign fetch_fin = final_cyc && (state_q == FETCH_ACC);
  // A trapped access reads as zero and never writes.
  assign rd_word   = mis_q ? 16'h0000 : mem_q[idx_q];
  assign store_en  = data_fin && wr_q && !mis_q;

  assign bus.mem_done  = data_fin;
  assign bus.if_valid  = fetch_fin;
  assign bus.mem_rdata = (data_fin && !wr_q) ? rd_word : mem_rdata_q;
  assign bus.if_rdata  = fetch_fin ? rd_word : if_rdata_q;
  assign bus.freeze_pc = ~fetch_fin;
  assign bus.stall_mem = data_req & ~data_fin;
  assign bus.busy      = (state_q != IDLE);
`ifdef MISALIGN_TRAP_EN
  assign bus.misalign_err = final_cyc & mis_q;
`endif

  always_ff @(posedge clk) begin
    if (rest) begin
      state_q     <= IDLE;
      wait_cnt_q  <= 4'd0;
      idx_q       <= '0;
      wr_q        <= 1'b0;
      wdata_q     <= 16'h0000;
      mis_q       <= 1'b0;
      if_rdata_q  <= 16'h0000;
      mem_rdata_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      idx_q      <= idx_d;
      wr_q       <= wr_d;
      wdata_q    <= wdata_d;
      mis_q      <= mis_d;
      if (data_fin && !wr_q) begin
        mem_rdata_q <= rd_word;
      end
      if (fetch_fin) begin
        if_rdata_q <= rd_word;
      end
    end
  end

  // Array is not reset; a reset landing on the final cycle cancels the store.
  always_ff @(posedge clk) begin
    if (store_en && !rest) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

endmodule

// File: doc/unified_mem_ctrl.md
Name: unified_mem_ctrl

Overview:
- Responder side of the shared instruction/data memory port used by the fetch stage.
- Arbitrates IF-stage fetch requests against MEM-stage load/store requests to one 16-bit word memory, and inserts programmable wait states.
- Generates the structural-hazard PC freeze the fetch stage consumes, plus the matching MEM-stage stall.
- Sits between the IF/MEM pipeline stages and the memory array, which it contains.

Parameters:
- DEPTH_LOG2, 10, memory depth in 16-bit words (2^DEPTH_LOG2 words).
- WAIT_CYCLES, 1, extra access cycles per transfer (0..15).

Ports:
- clk  input  1  system clock, rising edge.
- rest  input  1  synchronous reset, active-high.
- if_req  input  1  fetch request, level, held until if_valid.
- if_addr  input  16  fetch byte address (current PC).
- if_rdata  output  16  fetched instruction word.
- if_valid  output  1  fetch complete, one cycle.
- mem_read  input  1  data load request, level.
- mem_write  input  1  data store request, level.
- mem_addr  input  16  data byte address.
- mem_wdata  input  16  store data.
- mem_rdata  output  16  load data.
- mem_done  output  1  data access complete, one cycle.
- freeze_pc  output  1  hold PC (structural hazard / fetch pending).
- stall_mem  output  1  hold MEM stage and earlier stages.
- busy  output  1  access in progress.

Behaviour:
- Clock and reset: one clock clk; reset rest is synchronous and active-high.
- Word index: addr[DEPTH_LOG2:1]. addr[0] is ignored. Upper bits are ignored, so addresses wrap modulo memory size.
- FSM states:
  - IDLE.
  - DATA_ACC: serving a data request.
  - FETCH_ACC: serving a fetch.
- IDLE transitions:
  - (mem_read or mem_write) goes to DATA_ACC. Data has priority over fetch.
  - else if_req goes to FETCH_ACC.
  - else stays in IDLE.
- On entry to an ACC state:
  - Latch the address, the write flag and mem_wdata.
  - Load wait_cnt = WAIT_CYCLES.
- In an ACC state:
  - While wait_cnt != 0, decrement wait_cnt.
  - When wait_cnt == 0, this is the final cycle. Return to IDLE at the next edge.
- Latency: request sampled in IDLE cycle N. Done/valid is asserted in cycle N+1+WAIT_CYCLES. Requester holds signals until then. Minimum one IDLE cycle between accesses.
- Final cycle of DATA_ACC:
  - mem_done = 1.
  - On a load, mem_rdata = array[latched index], read combinationally from the latched address.
  - On a store, the array is written at the edge ending the final cycle.
- Final cycle of FETCH_ACC: if_valid = 1 and if_rdata = array[latched index].
- Outside their final cycle, mem_rdata and if_rdata hold their last value. Both are registered copies, reset to 0x0000.
- mem_read and mem_write both high: treated as a store.
- Request inputs change mid-access: ignored. The latched values are used.
- Requests dropped before done: the access still completes and pulses done. The requester ignores that pulse.
- freeze_pc = 1 in every cycle except one where if_valid = 1. This includes IDLE, so the PC advances only on a completed fetch.
- stall_mem = (mem_read or mem_write) and not mem_done.
- busy = state != IDLE.
- Reset values:
  - state IDLE, wait_cnt 0.
  - if_valid 0, mem_done 0, busy 0, stall_mem 0.
  - if_rdata and mem_rdata 0x0000.
  - freeze_pc 1.
- Reset mid-access: the access is abandoned with no array write and no done pulse. Array contents are unaffected by reset.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Enabled:
  - Adds output misalign_err (1 bit, reset 0).
  - A data request with mem_addr[0] = 1 still runs the full access and pulses mem_done.
  - The store is suppressed, and a load returns 0x0000.
  - misalign_err is high in that final cycle only.
  - Fetches with if_addr[0] = 1 behave the same way on if_valid.
- Disabled: no port. addr[0] is silently ignored.

Test Plan:
- Reset, then fetch: WAIT_CYCLES = 1, preload word 0 = 0x1234, if_req = 1 with if_addr = 0x0000 -> if_valid in cycle 2 after sampling, if_rdata = 0x1234, freeze_pc low only in that cycle.
- Store then load: mem_write with addr 0x0010 and data 0xBEEF, then mem_read addr 0x0010 -> mem_done pulses twice, mem_rdata = 0xBEEF, stall_mem high until each done.
- Simultaneous requests: if_req and mem_read asserted together in IDLE -> data served first (mem_done), fetch served next (if_valid), freeze_pc high throughout the data access.
- Address wrap: DEPTH_LOG2 = 10, store 0x00AA to 0x0802, load 0x0002 -> 0x00AA.
- Reset mid-store: rest asserted during DATA_ACC -> no mem_done, later load of that address returns the old value, state is IDLE.
- WAIT_CYCLES = 0 back-to-back fetches -> if_valid every 2 cycles. With MISALIGN_TRAP_EN, a store to 0x0011 -> misalign_err pulses and the array is unchanged.
